// File: rtl/ram_req_if.sv
// ram_req_if: request, response and RAM-side bus bundle for ram_req_ctrl
interface ram_req_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_wr_done;
  logic                  o_ram_en;
  logic                  o_ram_rw;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_wdata;
  logic                  i_ram_write_ack;
  logic                  i_ram_read_ack;
  logic [DATA_WIDTH-1:0] i_ram_rdata;
  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rsp_ready,
           i_ram_write_ack, i_ram_read_ack, i_ram_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_wr_done,
           o_ram_en, o_ram_rw, o_ram_addr, o_ram_wdata
  );
  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rsp_ready,
           i_ram_write_ack, i_ram_read_ack, i_ram_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_wr_done,
           o_ram_en, o_ram_rw, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: FIFO-buffered request sequencer for a single-port RAM.
// Define RAM_CTRL_ADDR_CHECK_EN to reject addresses >= RAM_DEPTH without touching the RAM.
module ram_req_ctrl #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 16000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  ram_req_if.slave                    io_bus,
  output logic                        o_ack_err,
  output logic                        o_addr_err,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (RAM_DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("RAM_DEPTH exceeds the address space");
  end
  state_t                r_state;
  logic [FIFO_DEPTH-1:0] r_fifo_write;
  logic [ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  r_ram_en;
  logic                  r_ram_rw;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_wr_done;
  logic                  r_ack_err;
  logic                  r_addr_err;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_write;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;
  logic                  w_head_oor;
  logic                  w_ack_bad;
  assign w_ready      = r_count != (PW+1)'(FIFO_DEPTH);
  assign w_push       = io_bus.i_req_valid && w_ready;
  assign w_pop        = (r_state == IDLE) && (r_count != '0);
  assign w_head_write = r_fifo_write[r_rd_ptr];
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_wdata = r_fifo_wdata[r_rd_ptr];
  // The acks must be exactly one-hot in the direction of the command in flight.
  assign w_ack_bad    = {io_bus.i_ram_write_ack, io_bus.i_ram_read_ack} != {r_ram_rw, !r_ram_rw};
`ifdef RAM_CTRL_ADDR_CHECK_EN
  assign w_head_oor   = 32'(w_head_addr) >= RAM_DEPTH;
`else
  assign w_head_oor   = 1'b0;
`endif
  // Request FIFO: storage, wrapping pointers and occupancy; push and pop may coincide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_write[r_wr_ptr] <= io_bus.i_req_write;
        r_fifo_addr[r_wr_ptr]  <= io_bus.i_req_addr;
        r_fifo_wdata[r_wr_ptr] <= io_bus.i_req_wdata;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // Sequencer: one command at a time; the RAM-side registers double as the command register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_wr_done   <= 1'b0;
      r_ack_err   <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_ram_en   <= 1'b0;
      r_wr_done  <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop && w_head_oor) begin
            r_addr_err <= 1'b1;
            if (!w_head_write) begin
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end
          end else if (w_pop) begin
            r_ram_en    <= 1'b1;
            r_ram_rw    <= w_head_write;
            r_ram_addr  <= w_head_addr;
            r_ram_wdata <= w_head_wdata;
            r_state     <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (w_ack_bad) r_ack_err <= 1'b1;
          if (r_ram_rw) begin
            r_wr_done <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_rsp_rdata <= io_bus.i_ram_rdata;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (io_bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io_bus.o_req_ready = w_ready;
  assign io_bus.o_rsp_valid = r_rsp_valid;
  assign io_bus.o_rsp_rdata = r_rsp_rdata;
  assign io_bus.o_wr_done   = r_wr_done;
  assign io_bus.o_ram_en    = r_ram_en;
  assign io_bus.o_ram_rw    = r_ram_rw;
  assign io_bus.o_ram_addr  = r_ram_addr;
  assign io_bus.o_ram_wdata = r_ram_wdata;
  assign o_ack_err          = r_ack_err;
  assign o_addr_err         = r_addr_err;
  assign o_busy             = (r_state != IDLE) || (r_count != '0);
  assign o_fifo_level       = r_count;
endmodule
